// File: rtl/addsub_mul_ctrl_pkg.sv
// Shared widths and state encoding for the shift-add multiplier controller.
package addsub_mul_ctrl_pkg;

    localparam int unsigned MUL_W  = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_CALC = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/addsub_mul_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier controller.
interface addsub_mul_ctrl_if;

    logic                                      start;
    logic [addsub_mul_ctrl_pkg::MUL_W-1:0]     a;
    logic [addsub_mul_ctrl_pkg::MUL_W-1:0]     b;
    logic                                      busy;
    logic                                      done;
    logic [addsub_mul_ctrl_pkg::PROD_W-1:0]    product;
    logic [addsub_mul_ctrl_pkg::CNT_W-1:0]     iter;

    modport master (output start, a, b, input busy, done, product, iter);
    modport slave  (input start, a, b, output busy, done, product, iter);

endinterface

// File: rtl/addsub_mul_ctrl_addsub.sv
// Existing W-bit adder/subtractor: m=0 adds, m=1 subtracts; c is carry-out, v signed overflow.
module addsub #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic [W-1:0] s,
    output logic         c,
    output logic         v
);

    logic [W-1:0] b_eff;
    logic [W:0]   sum;

    assign b_eff = b ^ {W{m}};
    assign sum   = {1'b0, a} + {1'b0, b_eff} + (W+1)'(m);
    assign s     = sum[W-1:0];
    assign c     = sum[W];
    assign v     = (a[W-1] == b_eff[W-1]) && (s[W-1] != a[W-1]);

endmodule

// File: rtl/addsub_mul_ctrl.sv
// Sequential 4x4 unsigned shift-add multiplier time-sharing one addsub instance.
module addsub_mul_ctrl
    import addsub_mul_ctrl_pkg::*;
#(
    parameter int unsigned N_ITER = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_mul_ctrl_if.slave   bus
);

    if (N_ITER != MUL_W) begin : g_bad_n_iter
        $error("addsub_mul_ctrl: N_ITER must equal the addsub width");
    end

    logic [ST_W-1:0]   state, state_nxt;
    logic [MUL_W-1:0]  mcand, mcand_nxt;
    logic [MUL_W-1:0]  acc_hi, acc_hi_nxt;
    logic [MUL_W-1:0]  acc_lo, acc_lo_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PROD_W-1:0] product_q, product_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;

    logic [MUL_W-1:0]  add_b;
    logic [MUL_W-1:0]  add_s;
    logic              add_c;
    logic              add_v_unused;
    logic [PROD_W-1:0] shifted;

    // Partial product: add mcand only when the current multiplier bit is set
    assign add_b = acc_lo[0] ? mcand : '0;

    addsub #(.W(MUL_W)) u_addsub (
        .a (acc_hi),
        .b (add_b),
        .m (1'b0),
        .s (add_s),
        .c (add_c),
        .v (add_v_unused)
    );

    // Carry is the 9th bit of the partial sum; dropping acc_lo[0] is the right shift
    assign shifted = {add_c, add_s, acc_lo[MUL_W-1:1]};

    always_comb begin
        state_nxt   = state;
        mcand_nxt   = mcand;
        acc_hi_nxt  = acc_hi;
        acc_lo_nxt  = acc_lo;
        cnt_nxt     = cnt;
        product_nxt = product_q;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_nxt  = bus.a;
                    acc_lo_nxt = bus.b;
                    acc_hi_nxt = '0;
                    cnt_nxt    = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = ST_CALC;
                end
            end
            ST_CALC: begin
                {acc_hi_nxt, acc_lo_nxt} = shifted;
                cnt_nxt                  = cnt + 1'b1;
                if (cnt == CNT_W'(N_ITER - 1)) begin
                    product_nxt = shifted;
                    done_nxt    = 1'b1;
                    state_nxt   = ST_DONE;
                end else begin
                    busy_nxt    = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            mcand     <= mcand_nxt;
            acc_hi    <= acc_hi_nxt;
            acc_lo    <= acc_lo_nxt;
            cnt       <= cnt_nxt;
            product_q <= product_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.iter    = cnt;

endmodule

// File: tb/tb_addsub_mul_ctrl.sv
// Randomized and directed checks of addsub_mul_ctrl against a cycle-timeline reference model.
module tb_addsub_mul_ctrl;

    logic clk;
    logic rst_n;

    addsub_mul_ctrl_if bus ();

    addsub_mul_ctrl #(.N_ITER(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference: k = edges since the accepting edge (-1 when idle)
    int         k;
    logic [7:0] pend;
    logic [7:0] exp_prod;
    int         m_done_cnt;
    int         d_done_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge(input logic st, input logic [3:0] av, input logic [3:0] bv);
        if (!rst_n) begin
            k        = -1;
            exp_prod = 8'h00;
        end else if (k < 0) begin
            if (st) begin
                k    = 0;
                pend = 8'(av) * 8'(bv);
            end
        end else begin
            k++;
            if (k == 4) begin
                exp_prod = pend;
                m_done_cnt++;
            end
            if (k == 5) k = -1;
        end
    endtask

    task automatic check_outputs();
        logic       e_busy;
        logic       e_done;
        logic [1:0] e_iter;
        e_busy = (k >= 0 && k <= 3);
        e_done = (k == 4);
        e_iter = e_busy ? 2'(k) : 2'd0;
        if (bus.done === 1'b1) d_done_cnt++;
        check("busy",    32'(bus.busy),    32'(e_busy));
        check("done",    32'(bus.done),    32'(e_done));
        check("product", 32'(bus.product), 32'(exp_prod));
        check("iter",    32'(bus.iter),    32'(e_iter));
    endtask

    // Drive inputs at the negedge, model the rising edge, sample at the next negedge
    task automatic step(input logic st, input logic [3:0] av, input logic [3:0] bv);
        bus.start = st;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        model_edge(st, av, bv);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_op(input logic [3:0] av, input logic [3:0] bv);
        step(1'b1, av, bv);
        repeat (6) step(1'b0, 4'($urandom), 4'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(bus.busy),    32'd0);
        check({tag, "_done"},    32'(bus.done),    32'd0);
        check({tag, "_product"}, 32'(bus.product), 32'd0);
        check({tag, "_iter"},    32'(bus.iter),    32'd0);
    endtask

    initial begin
        int d0;
        n_vec      = 0;
        n_err      = 0;
        k          = -1;
        pend       = 8'h00;
        exp_prod   = 8'h00;
        m_done_cnt = 0;
        d_done_cnt = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.a      = 4'h0;
        bus.b      = 4'h0;

        #1;
        check_reset_outputs("reset");
        step(1'b1, 4'h5, 4'h5);
        step(1'b1, 4'h5, 4'h5);
        rst_n = 1'b1;
        step(1'b0, 4'h0, 4'h0);

        // Directed products and latency
        d0 = d_done_cnt;
        run_op(4'hF, 4'hF);
        check("prod_f_f", 32'(bus.product), 32'h0E1);
        check("done_once_f_f", 32'(d_done_cnt - d0), 32'd1);
        run_op(4'hD, 4'hB);
        check("prod_d_b", 32'(bus.product), 32'h08F);
        run_op(4'h0, 4'h9);
        check("prod_0_9", 32'(bus.product), 32'h000);

        // Start re-pulsed mid-operation with new operands is ignored
        d0 = d_done_cnt;
        step(1'b1, 4'h3, 4'h5);
        step(1'b0, 4'h3, 4'h5);
        step(1'b1, 4'hE, 4'h7);
        repeat (5) step(1'b0, 4'h0, 4'h0);
        check("prod_ignore", 32'(bus.product), 32'h00F);
        check("done_once_ignore", 32'(d_done_cnt - d0), 32'd1);

        // start held high: back-to-back operations
        d0 = d_done_cnt;
        step(1'b1, 4'h2, 4'h3);
        repeat (5) step(1'b1, 4'h4, 4'h4);
        check("prod_b2b_first", 32'(bus.product), 32'h006);
        repeat (6) step(1'b1, 4'h4, 4'h4);
        check("prod_b2b_second", 32'(bus.product), 32'h010);
        step(1'b0, 4'h0, 4'h0);
        repeat (6) step(1'b0, 4'h0, 4'h0);

        // Asynchronous reset mid-CALC
        d0 = d_done_cnt;
        step(1'b1, 4'h7, 4'h9);
        step(1'b0, 4'h0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        k        = -1;
        exp_prod = 8'h00;
        check_reset_outputs("midreset");
        @(negedge clk);
        step(1'b0, 4'h0, 4'h0);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 4'h0, 4'h0);
        check("no_done_after_reset", 32'(d_done_cnt - d0), 32'd0);
        run_op(4'h1, 4'h1);
        check("prod_1_1", 32'(bus.product), 32'h001);

        // Exhaustive sweep
        d0 = d_done_cnt;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = 8'(i);
            step(1'b1, ab[7:4], ab[3:0]);
            repeat (5) step(1'b0, 4'($urandom), 4'($urandom));
            check("sweep_prod", 32'(bus.product), 32'(8'(ab[7:4]) * 8'(ab[3:0])));
        end
        check("sweep_done_cnt", 32'(d_done_cnt - d0), 32'd256);

        // Random start/operand traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
        end
        repeat (8) step(1'b0, 4'h0, 4'h0);
        check("total_done_cnt", 32'(d_done_cnt), 32'(m_done_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
